// File: rtl/counter_pkg.sv
// counter_pkg: shared types and constants for the counter command sequencer.
//   cmd_op_e    - host command opcodes (LOAD/UP/DOWN/HOLD)
//   drv_state_e - sequencer FSM states
//   CNT_WIDTH   - default counter/operand width
//   cmd_t       - one queued command at the default width
//   sat_inc8    - saturating increment for 8-bit event counters
package counter_pkg;

  localparam int CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_HOLD = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } drv_state_e;

  // Layout used in the FIFO: opcode in the top two bits, operand below.
  typedef struct packed {
    cmd_op_e               op;
    logic [CNT_WIDTH-1:0]  arg;
  } cmd_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/counter_cmd_fifo.sv
// counter_cmd_fifo: small synchronous command FIFO, no bypass path.
//   clk, rst_n  - clock, asynchronous active-low reset (flushes occupancy)
//   push, din   - write strobe and data; ignored while full
//   pop, dout   - read strobe; dout always shows the head entry
//   full, empty - occupancy flags
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module counter_cmd_fifo
  import counter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(cmd_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/counter_driver.sv
// counter_driver: command sequencer driving an up/down counter with load.
//   clk, rst_n              - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     - host command handshake
//   cmd_op, cmd_arg         - opcode and operand (load value or cycle count)
//   cnt_load, cnt_load_val  - registered load strobe and value to the counter
//   cnt_en, cnt_up          - registered enable and direction to the counter
//   cnt_value               - counter readback
//   exp_value               - internal model of the counter value
//   busy, done              - activity flag, one-cycle completion pulse
//   err, err_cnt, err_clr   - sticky mismatch flag, saturating count, clear
//   dbg_state               - current FSM state for observation
//
// Handshake: a command transfers on every rising clk edge where
// cmd_valid && cmd_ready; cmd_ready is simply !full, independent of cmd_valid,
// and the host must hold cmd_op/cmd_arg stable while cmd_valid is high.
module counter_driver
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             cnt_up,
  input  logic [WIDTH-1:0] cnt_value,
  output logic [WIDTH-1:0] exp_value,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       err_cnt,
  input  logic             err_clr,
  output drv_state_e       dbg_state
);

  localparam int DW = WIDTH + 2;

  // ---------------------------------------------------------------- FIFO
  logic [DW-1:0]    fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  cmd_op_e          head_op;
  logic [WIDTH-1:0] head_arg;

  counter_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .din   ({cmd_op, cmd_arg}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign head_op   = cmd_op_e'(fifo_dout[DW-1:WIDTH]);
  assign head_arg  = fifo_dout[WIDTH-1:0];

  // ---------------------------------------------------------------- FSM
  drv_state_e       state, state_d;
  cmd_op_e          cur_op, cur_op_d;
  logic [WIDTH-1:0] remain, remain_d;
  logic             load_d;
  logic [WIDTH-1:0] load_val_d;
  logic             en_d;
  logic             up_d;
  logic             mismatch;

  // Drive pins are computed one cycle ahead and registered, so the pins are
  // already correct in the first cycle spent in EXEC. remain counts the EXEC
  // cycles still to go after the current one.
  always_comb begin
    state_d    = state;
    cur_op_d   = cur_op;
    remain_d   = remain;
    load_d     = 1'b0;
    load_val_d = cnt_load_val;
    en_d       = 1'b0;
    up_d       = 1'b0;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          cur_op_d = head_op;
          case (head_op)
            OP_LOAD: begin
              state_d    = ST_EXEC;
              remain_d   = '0;
              load_d     = 1'b1;
              load_val_d = head_arg;
            end
            OP_UP, OP_DOWN: begin
              if (head_arg == '0) begin
                state_d = ST_SETTLE;
              end else begin
                state_d  = ST_EXEC;
                remain_d = head_arg - 1'b1;
                en_d     = 1'b1;
                up_d     = (head_op == OP_UP);
              end
            end
            default: begin // OP_HOLD: pins stay low
              if (head_arg == '0) begin
                state_d = ST_SETTLE;
              end else begin
                state_d  = ST_EXEC;
                remain_d = head_arg - 1'b1;
              end
            end
          endcase
        end
      end
      ST_EXEC: begin
        if (remain == '0) begin
          state_d = ST_SETTLE;
        end else begin
          remain_d = remain - 1'b1;
          en_d     = (cur_op == OP_UP) || (cur_op == OP_DOWN);
          up_d     = (cur_op == OP_UP);
        end
      end
      ST_SETTLE: state_d = ST_CHECK;
      default:   state_d = ST_IDLE; // ST_CHECK
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cur_op       <= OP_LOAD;
      remain       <= '0;
      cnt_load     <= 1'b0;
      cnt_load_val <= '0;
      cnt_en       <= 1'b0;
      cnt_up       <= 1'b0;
    end else begin
      state        <= state_d;
      cur_op       <= cur_op_d;
      remain       <= remain_d;
      cnt_load     <= load_d;
      cnt_load_val <= load_val_d;
      cnt_en       <= en_d;
      cnt_up       <= up_d;
    end
  end

  // ------------------------------------------------------- expected model
  // Follows the registered pins with the same rule as the counter, so both
  // update on the same edge and agree by the CHECK cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_value <= '0;
    end else if (cnt_load) begin
      exp_value <= cnt_load_val;
    end else if (cnt_en) begin
      exp_value <= cnt_up ? exp_value + 1'b1 : exp_value - 1'b1;
    end
  end

  // ---------------------------------------------------------- error status
  assign mismatch = (state == ST_CHECK) && (cnt_value != exp_value);

  // A mismatch in the same cycle as err_clr wins: the clear is applied first,
  // then the new mismatch counted, leaving err=1 and err_cnt=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else if (mismatch) begin
      err     <= 1'b1;
      err_cnt <= err_clr ? 8'd1 : sat_inc8(err_cnt);
    end else if (err_clr) begin
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end
  end

  assign done      = (state == ST_CHECK);
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign dbg_state = state;

endmodule

// File: tb/tb_counter_driver.sv
module tb_counter_driver;
  import counter_pkg::*;

  // ------------------------------------------------------ clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------ DUT
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       cnt_load;
  logic [7:0] cnt_load_val;
  logic       cnt_en;
  logic       cnt_up;
  logic [7:0] cnt_value;
  logic [7:0] exp_value;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] err_cnt;
  logic       err_clr;
  drv_state_e dbg_state;

  counter_driver #(.WIDTH(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_en       (cnt_en),
    .cnt_up       (cnt_up),
    .cnt_value    (cnt_value),
    .exp_value    (exp_value),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_cnt      (err_cnt),
    .err_clr      (err_clr),
    .dbg_state    (dbg_state)
  );

  // --------------------------------------------- counter being driven
  // skip_at selects one enabled cycle (by running enable count) to drop.
  int en_total = 0;
  int skip_at  = -1;
  always @(posedge clk) if (cnt_en) en_total <= en_total + 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            cnt_value <= 8'd0;
    else if (cnt_load)                     cnt_value <= cnt_load_val;
    else if (cnt_en && en_total != skip_at) cnt_value <= cnt_up ? cnt_value + 8'd1 : cnt_value - 8'd1;
  end

  // ------------------------------------------------------------- checker
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];
  int mon_idx     = 0;
  int done_cnt    = 0;
  int load_cycles = 0;
  int en_cycles   = 0;
  int up_cycles   = 0;
  int overlap     = 0;
  logic [7:0] last_load_val = 8'd0;

  always @(negedge clk) begin
    if (cnt_load) begin
      load_cycles++;
      last_load_val = cnt_load_val;
    end
    if (cnt_en) en_cycles++;
    if (cnt_en && cnt_up) up_cycles++;
    if (cnt_load && cnt_en) overlap++;
    if (done) begin
      done_cnt++;
      if (mon_idx < exp_q.size()) begin
        check("done_exp", exp_value, exp_q[mon_idx]);
        mon_idx++;
      end else begin
        check("done_extra", done_cnt, mon_idx);
      end
    end
  end

  // -------------------------------------------------------- driver tasks
  // Called just after a negedge; returns at the negedge following the push edge.
  task automatic push(input logic [1:0] op, input logic [7:0] arg);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("push_timeout", n, 0);
    else @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run(input logic [1:0] op, input logic [7:0] arg, input logic [7:0] expv);
    exp_q.push_back(expv);
    push(op, arg);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check(tag, busy, 0);
  endtask

  task automatic wait_done(output int at);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    at = (n >= 100) ? -1000 : cyc;
  endtask

  // ------------------------------------------------------------ stimulus
  int l0, e0, u0, d0, t0, td, t4, t5;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_arg   = 8'd0;
    err_clr   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_pins", {cnt_load, cnt_en, cnt_up, cnt_load_val}, 0);
    check("rst_status", {busy, done, err, err_cnt, exp_value}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD 0x10 then UP 5
    l0 = load_cycles; e0 = en_cycles; u0 = up_cycles; d0 = done_cnt;
    run(OP_LOAD, 8'h10, 8'h10);
    run(OP_UP, 8'd5, 8'h15);
    wait_idle("t1_idle");
    check("t1_load_cycles", load_cycles - l0, 1);
    check("t1_load_val", last_load_val, 8'h10);
    check("t1_en_cycles", en_cycles - e0, 5);
    check("t1_up_cycles", up_cycles - u0, 5);
    check("t1_dones", done_cnt - d0, 2);
    check("t1_exp", exp_value, 8'h15);
    check("t1_cnt", cnt_value, 8'h15);
    check("t1_err", err, 0);

    // wrap upward, then wrap downward
    e0 = en_cycles; u0 = up_cycles;
    run(OP_LOAD, 8'hFE, 8'hFE);
    run(OP_UP, 8'd3, 8'h01);
    wait_idle("t2_idle_a");
    check("t2_exp_up", exp_value, 8'h01);
    check("t2_err_up", err, 0);
    run(OP_DOWN, 8'd2, 8'hFF);
    wait_idle("t2_idle_b");
    check("t2_exp_down", exp_value, 8'hFF);
    check("t2_cnt_down", cnt_value, 8'hFF);
    check("t2_en_cycles", en_cycles - e0, 5);
    check("t2_up_cycles", up_cycles - u0, 3);
    check("t2_err_down", err, 0);

    // UP 0 and HOLD 4: latency counted in cycles from the push edge to the done cycle inclusive
    e0 = en_cycles; l0 = load_cycles;
    run(OP_UP, 8'd0, 8'hFF);
    t0 = cyc;
    wait_done(td);
    check("up0_latency", td - t0 + 1, 3);
    wait_idle("t3_idle_a");
    run(OP_HOLD, 8'd4, 8'hFF);
    t0 = cyc;
    wait_done(td);
    check("hold4_latency", td - t0 + 1, 7);
    wait_idle("t3_idle_b");
    check("t3_no_en", en_cycles - e0, 0);
    check("t3_no_load", load_cycles - l0, 0);
    check("t3_exp", exp_value, 8'hFF);

    // FIFO fill while a long UP runs
    d0 = done_cnt;
    run(OP_UP, 8'd200, 8'hC7);
    repeat (2) @(negedge clk);
    run(OP_LOAD, 8'h20, 8'h20);
    run(OP_UP, 8'd3, 8'h23);
    run(OP_DOWN, 8'd1, 8'h22);
    check("t4_ready_before_4th", cmd_ready, 1);
    run(OP_HOLD, 8'd2, 8'h22);
    check("t4_ready_full", cmd_ready, 0);
    check("t4_busy", busy, 1);
    t4 = cyc;
    run(OP_UP, 8'h10, 8'h32);
    t5 = cyc;
    check("t4_fifth_stalled", (t5 - t4) > 150, 1);
    wait_idle("t4_idle");
    check("t4_dones", done_cnt - d0, 6);
    check("t4_exp", exp_value, 8'h32);
    check("t4_err", err, 0);

    // counter drops one increment -> mismatch
    run(OP_LOAD, 8'h40, 8'h40);
    wait_idle("t5_idle_a");
    skip_at = en_total + 1;
    run(OP_UP, 8'd3, 8'h43);
    wait_idle("t5_idle_b");
    check("t5_cnt_skipped", cnt_value, 8'h42);
    check("t5_err", err, 1);
    check("t5_err_cnt", err_cnt, 1);
    // second mismatch with err_clr in its CHECK cycle
    run(OP_HOLD, 8'd1, 8'h43);
    wait_done(td);
    check("t5_done_seen", td >= 0, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t5_clr_vs_mm_err", err, 1);
    check("t5_clr_vs_mm_cnt", err_cnt, 1);
    wait_idle("t5_idle_c");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t5_clr_err", err, 0);
    check("t5_clr_cnt", err_cnt, 0);
    run(OP_LOAD, 8'h55, 8'h55);
    wait_idle("t5_idle_d");
    check("t5_resync_err", err, 0);

    // reset in the middle of UP 100: no scoreboard entry, no done expected
    push(OP_UP, 8'd100);
    repeat (20) @(negedge clk);
    check("t6_running", cnt_en, 1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_en", cnt_en, 0);
    check("t6_async_exp", exp_value, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_ready", cmd_ready, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_idle", {busy, cnt_en, cnt_load}, 0);
    check("t6_cnt_reset", cnt_value, 0);
    run(OP_LOAD, 8'h33, 8'h33);
    wait_idle("t6_idle_b");
    check("t6_exp", exp_value, 8'h33);
    check("t6_cnt", cnt_value, 8'h33);
    check("t6_err", err, 0);

    check("never_load_and_en", overlap, 0);
    check("all_done_seen", mon_idx, exp_q.size());
    check("done_total", done_cnt, 18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
